cache_axi_arbiter: RTL and testbench

Downstream of the instruction cache and data cache: accepts single-word miss/uncached requests from both, picks one, and runs it as a single-beat AXI transaction on the core's only AXI master port. Instruction side is read-only; data side may read or write. Completion is returned as a one-cycle `*_dok` pulse with read data held alongside, matching the cache-side handshake: cache holds `req`/`addr` until `dok`, then writes its line.

---
 rtl/cache_axi_arbiter.sv | 164 ++++++++++++++++
 tb/tb_cache_axi_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_arbiter.sv
// Arbitrates I-cache and D-cache single-word requests onto one AXI master, one transaction at a time.
// `define ARB_ROUND_ROBIN_EN for alternating grants; default build gives data fixed priority over inst.
module cache_axi_arbiter #(
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_cache_req,
  input  logic [31:0]     inst_cache_addr,
  output logic [31:0]     inst_cache_rdata,
  output logic            inst_cache_dok,
  input  logic            data_cache_req,
  input  logic            data_cache_wr,
  input  logic [31:0]     data_cache_addr,
  input  logic [31:0]     data_cache_wdata,
  input  logic [3:0]      data_cache_wstrb,
  output logic [31:0]     data_cache_rdata,
  output logic            data_cache_dok,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  output logic [ID_W-1:0] wid,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        any_req;
  logic        grant_data;
  logic        owner_data;
  logic [31:0] addr_q;
  logic        unused_ok;

  assign any_req   = inst_cache_req || data_cache_req;
  assign unused_ok = ^{rid, rresp, rlast, bid, bresp};

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_data;

  assign grant_data = data_cache_req && (!inst_cache_req || rr_data);

  // Pointer always moves to the side that was not just granted.
  always_ff @(posedge clk) begin
    if (reset)
      rr_data <= 1'b1;
    else if (state == S_IDLE && any_req)
      rr_data <= !grant_data;
  end
`else
  assign grant_data = data_cache_req;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = (grant_data && data_cache_wr) ? S_AW_W : S_AR;
      S_AR:    if (arready) state_nxt = S_R;
      S_R:     if (rvalid) state_nxt = S_DONE;
      S_AW_W:  if ((!awvalid || awready) && (!wvalid || wready)) state_nxt = S_B;
      S_B:     if (bvalid) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake and completion outputs are flops loaded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      arvalid          <= 1'b0;
      rready           <= 1'b0;
      awvalid          <= 1'b0;
      wvalid           <= 1'b0;
      bready           <= 1'b0;
      inst_cache_dok   <= 1'b0;
      data_cache_dok   <= 1'b0;
      inst_cache_rdata <= 32'd0;
      data_cache_rdata <= 32'd0;
      owner_data       <= 1'b0;
      addr_q           <= 32'd0;
      wdata            <= 32'd0;
      wstrb            <= 4'd0;
    end else begin
      arvalid        <= (state_nxt == S_AR);
      rready         <= (state_nxt == S_R);
      bready         <= (state_nxt == S_B);
      inst_cache_dok <= (state_nxt == S_DONE) && !owner_data;
      data_cache_dok <= (state_nxt == S_DONE) && owner_data;

      if (state != S_AW_W && state_nxt == S_AW_W) begin
        awvalid <= 1'b1;
        wvalid  <= 1'b1;
      end else if (state == S_AW_W) begin
        if (awready) awvalid <= 1'b0;
        if (wready)  wvalid  <= 1'b0;
      end else begin
        awvalid <= 1'b0;
        wvalid  <= 1'b0;
      end

      if (state == S_IDLE && any_req) begin
        owner_data <= grant_data;
        addr_q     <= grant_data ? data_cache_addr : inst_cache_addr;
        if (grant_data) begin
          wdata <= data_cache_wdata;
          wstrb <= data_cache_wstrb;
        end
      end

      if (state == S_R && rvalid) begin
        if (owner_data)
          data_cache_rdata <= rdata;
        else
          inst_cache_rdata <= rdata;
      end
    end
  end

  assign arid    = ID_W'(owner_data);
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign awid    = ID_W'(1);
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign wid     = ID_W'(1);
  assign wlast   = 1'b1;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Randomized bench for cache_axi_arbiter: transaction-level cache/AXI-slave model plus directed timing cases.
module tb_cache_axi_arbiter;
  localparam int ID_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic            inst_cache_req = 0, inst_cache_dok;
  logic [31:0]     inst_cache_addr = 0, inst_cache_rdata;
  logic            data_cache_req = 0, data_cache_wr = 0, data_cache_dok;
  logic [31:0]     data_cache_addr = 0, data_cache_wdata = 0, data_cache_rdata;
  logic [3:0]      data_cache_wstrb = 0;
  logic [ID_W-1:0] arid, awid, wid;
  logic [ID_W-1:0] rid = 0, bid = 0;
  logic [31:0]     araddr, awaddr, wdata;
  logic [31:0]     rdata = 0;
  logic [7:0]      arlen, awlen;
  logic [2:0]      arsize, awsize;
  logic [1:0]      arburst, awburst;
  logic [1:0]      rresp = 0, bresp = 0;
  logic [3:0]      wstrb;
  logic            arvalid, rready, awvalid, wvalid, wlast, bready;
  logic            arready = 0, rvalid = 0, rlast = 0, awready = 0, wready = 0, bvalid = 0;

  cache_axi_arbiter #(.ID_W(ID_W)) dut (
    .clk(clk), .reset(reset),
    .inst_cache_req(inst_cache_req), .inst_cache_addr(inst_cache_addr),
    .inst_cache_rdata(inst_cache_rdata), .inst_cache_dok(inst_cache_dok),
    .data_cache_req(data_cache_req), .data_cache_wr(data_cache_wr),
    .data_cache_addr(data_cache_addr), .data_cache_wdata(data_cache_wdata),
    .data_cache_wstrb(data_cache_wstrb), .data_cache_rdata(data_cache_rdata),
    .data_cache_dok(data_cache_dok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: one outstanding transfer, tracked by which handshakes remain.
  bit          busy, done_now, t_data, t_wr, ar_pend, aw_pend, w_pend, r_wait, b_wait;
  logic [31:0] t_addr, t_wdata, r_word;
  logic [3:0]  t_wstrb;
  int          ar_dly, aw_dly, w_dly, r_dly, b_dly;
  bit          rr_data = 1'b1;
  logic [31:0] exp_ird = 0, exp_drd = 0;
  int          cyc = 0, n_dok = 0, dok_cyc = 0;
  bit          auto_req = 0;
  int          req_rate = 0, max_dly = 0;
  int          f_ar = 0, f_aw = 0, f_w = 0, f_r = 0, f_b = 0;
  bit          f_rd_en = 0;
  logic [31:0] f_rd_val = 0;
  int          grant_log[$];

  function automatic int pick(input int f);
    return (f >= 0) ? f : int'($urandom_range(0, max_dly));
  endfunction

  // One cycle, entered and left at a falling edge.
  task automatic step();
    bit e_ar, e_r, e_aw, e_w, e_b, n_busy, n_done;
    e_ar = busy && !t_wr && ar_pend;
    e_r  = busy && !t_wr && !ar_pend && r_wait;
    e_aw = busy && t_wr && aw_pend;
    e_w  = busy && t_wr && w_pend;
    e_b  = busy && t_wr && !aw_pend && !w_pend && b_wait;
    check("arvalid", arvalid, e_ar);
    check("rready", rready, e_r);
    check("awvalid", awvalid, e_aw);
    check("wvalid", wvalid, e_w);
    check("bready", bready, e_b);
    check("inst_dok", inst_cache_dok, done_now && !t_data);
    check("data_dok", data_cache_dok, done_now && t_data);
    if (e_ar) begin
      check("araddr", araddr, t_addr);
      check("arid", arid, {{(ID_W-1){1'b0}}, t_data});
    end
    if (e_aw) begin
      check("awaddr", awaddr, t_addr);
      check("awid", awid, 1);
    end
    if (e_w) begin
      check("wdata", wdata, t_wdata);
      check("wstrb", wstrb, t_wstrb);
    end
    if (e_ar || e_aw)
      check("axi_const", {arlen, arsize, arburst, awlen, awsize, awburst, wlast, wid},
            {8'd0, 3'b010, 2'b01, 8'd0, 3'b010, 2'b01, 1'b1, ID_W'(1)});
    if (done_now) begin
      check("inst_rdata", inst_cache_rdata, exp_ird);
      check("data_rdata", data_cache_rdata, exp_drd);
      n_dok++;
      dok_cyc = cyc;
      grant_log.push_back(int'(t_data));
      if (t_data) data_cache_req = 0; else inst_cache_req = 0;
    end

    if (reset) begin
      busy = 0; done_now = 0; rr_data = 1; exp_ird = 0; exp_drd = 0;
      inst_cache_req = 0; data_cache_req = 0;
      arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    end else begin
      if (auto_req) begin
        if (!inst_cache_req && $urandom_range(0, 99) < req_rate) begin
          inst_cache_req  = 1;
          inst_cache_addr = $urandom;
        end
        if (!data_cache_req && $urandom_range(0, 99) < req_rate) begin
          data_cache_req   = 1;
          data_cache_wr    = $urandom_range(0, 1);
          data_cache_addr  = $urandom;
          data_cache_wdata = $urandom;
          data_cache_wstrb = $urandom;
        end
      end

      n_busy = busy;
      n_done = 0;
      rvalid = 0;
      rdata  = $urandom;
      rid    = $urandom;
      rresp  = $urandom;
      if (e_r) begin
        if (r_dly > 0) r_dly--;
        else begin
          rvalid = 1; rdata = r_word; r_wait = 0; n_busy = 0; n_done = 1;
          if (t_data) exp_drd = r_word; else exp_ird = r_word;
        end
      end
      arready = $urandom_range(0, 1);
      if (e_ar) begin
        if (ar_dly > 0) begin arready = 0; ar_dly--; end
        else begin arready = 1; ar_pend = 0; r_wait = 1; end
      end
      awready = $urandom_range(0, 1);
      if (e_aw) begin
        if (aw_dly > 0) begin awready = 0; aw_dly--; end
        else begin awready = 1; aw_pend = 0; end
      end
      wready = $urandom_range(0, 1);
      if (e_w) begin
        if (w_dly > 0) begin wready = 0; w_dly--; end
        else begin wready = 1; w_pend = 0; end
      end
      bvalid = 0;
      bid    = $urandom;
      bresp  = $urandom;
      if (e_b) begin
        if (b_dly > 0) b_dly--;
        else begin bvalid = 1; b_wait = 0; n_busy = 0; n_done = 1; end
      end

      // The arbiter only looks at requests in a cycle with no transfer and no completion.
      if (!busy && !done_now && (inst_cache_req || data_cache_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (inst_cache_req && data_cache_req) t_data = rr_data;
        else t_data = data_cache_req;
        rr_data = !t_data;
`else
        t_data = data_cache_req;
`endif
        t_wr    = t_data && data_cache_wr;
        t_addr  = t_data ? data_cache_addr : inst_cache_addr;
        t_wdata = data_cache_wdata;
        t_wstrb = data_cache_wstrb;
        ar_pend = !t_wr; aw_pend = t_wr; w_pend = t_wr; b_wait = t_wr; r_wait = 0;
        ar_dly = pick(f_ar); aw_dly = pick(f_aw); w_dly = pick(f_w);
        r_dly = pick(f_r); b_dly = pick(f_b);
        r_word = f_rd_en ? f_rd_val : $urandom;
        n_busy = 1;
      end
      busy = n_busy;
      done_now = n_done;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_to_dok(input string tag, input int t0, output int lat);
    int k = n_dok;
    for (int i = 0; i < 80 && n_dok == k; i++) step();
    check({tag, "_timeout"}, n_dok == k, 0);
    lat = dok_cyc - t0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (inst_cache_req || data_cache_req || busy || done_now); i++) step();
    check("drain_idle", inst_cache_req || data_cache_req || busy || done_now, 0);
  endtask

  task automatic reset_cycle();
    reset = 1;
    step();
    reset = 0;
  endtask

  initial begin
    int lat, t0;
    int exp_order[4];
    logic [31:0] prev;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
    check("rst_doks", {inst_cache_dok, data_cache_dok}, 0);
    check("rst_inst_rdata", inst_cache_rdata, 0);
    check("rst_data_rdata", data_cache_rdata, 0);
    check("rst_araddr", araddr, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_wstrb", wstrb, 0);
    reset = 0;

    // Zero-wait instruction read.
    f_rd_en = 1; f_rd_val = 32'h2402_0001;
    inst_cache_addr = 32'hBFC0_0000; inst_cache_req = 1;
    t0 = cyc;
    run_to_dok("inst_rd", t0, lat);
    check("inst_rd_latency", lat, 3);
    check("inst_rd_value", inst_cache_rdata, 32'h2402_0001);
    f_rd_en = 0;

    // Write with W channel held off three cycles after AW completes.
    f_w = 3;
    prev = exp_drd;
    data_cache_wr = 1; data_cache_addr = 32'h8000_0010;
    data_cache_wdata = 32'hDEAD_BEEF; data_cache_wstrb = 4'b0011; data_cache_req = 1;
    t0 = cyc;
    run_to_dok("wr", t0, lat);
    check("wr_latency", lat, 6);
    check("wr_rdata_kept", data_cache_rdata, prev);
    f_w = 0;

    // AR accepted only after five stalled cycles.
    f_ar = 5;
    inst_cache_addr = 32'h0000_1234; inst_cache_req = 1;
    t0 = cyc;
    run_to_dok("ar_stall", t0, lat);
    check("ar_stall_latency", lat, 8);
    f_ar = 0;

    // Requester withdraws mid-transfer; completion still signalled.
    f_r = 2;
    inst_cache_addr = 32'h0000_4000; inst_cache_req = 1;
    t0 = cyc;
    step(); step();
    inst_cache_req = 0;
    run_to_dok("drop", t0, lat);
    check("drop_latency", lat, 5);
    f_r = 0;

    // Both sides requesting continuously.
    reset_cycle();
    grant_log.delete();
    auto_req = 1; req_rate = 100;
    for (int i = 0; i < 100 && grant_log.size() < 4; i++) step();
    auto_req = 0;
    drain();
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1, 0, 1, 0};
`else
    exp_order = '{1, 1, 1, 1};
`endif
    check("grant_count", grant_log.size() >= 4, 1);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check($sformatf("grant_order%0d", i), grant_log[i], exp_order[i]);

    // Reset while waiting for R.
    f_r = 4;
    inst_cache_addr = 32'h0000_8000; inst_cache_req = 1;
    step(); step();
    check("in_r_state", rready, 1);
    reset_cycle();
    check("rst_mid_rready", rready, 0);
    check("rst_mid_arvalid", arvalid, 0);
    check("rst_mid_dok", inst_cache_dok, 0);
    check("rst_mid_rdata", inst_cache_rdata, 0);
    f_r = 0;
    inst_cache_addr = 32'h0000_9000; inst_cache_req = 1;
    t0 = cyc;
    run_to_dok("post_rst", t0, lat);
    check("post_rst_latency", lat, 3);

    // Random traffic with random slave delays and occasional resets.
    f_ar = -1; f_aw = -1; f_w = -1; f_r = -1; f_b = -1;
    max_dly = 3; auto_req = 1; req_rate = 30;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 399) == 0) reset = 1;
      step();
      reset = 0;
    end
    auto_req = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
